// File: rtl/dac_tones_generator_mc.sv
// Multi-channel tone generator: per-channel phase accumulators produce square,
// sawtooth or triangle samples that are streamed as 24-bit serial DAC frames.
module dac_tones_generator_mc #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 16,
  parameter int PHASE_W    = 24,
  parameter int SAMPLE_DIV = 1000,
  parameter int SPI_DIV    = 2,
  parameter int BASE_STEP  = 1000
) (
  input  logic              clock_clk,
  input  logic              reset_reset,
  input  logic [4:0]        switches_switches_in,
  input  logic [1:0]        mode_in,
  input  logic              enable_in,
  output logic              spi_data_data,
  output logic              spi_data_spi_clk,
  output logic              spi_data_spi_sync,
  output logic [DATA_W-1:0] dac_out_data_dac,
  output logic              frame_done,
  output logic              overrun
);
  // state | meaning: IDLE wait for samples; LOAD sync low + MSB; SHIFT 24 bits; GAP sync high
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam int DIV_W = $clog2(2 * SPI_DIV);
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_tick_cnt;
  logic               r_latch;
  logic [PHASE_W-1:0] r_acc [8];
  logic [DATA_W-1:0]  r_buf [8];
  logic [2:0]         r_ch;
  logic [4:0]         r_bit_cnt;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [23:0]        r_shreg;

  logic               w_tick;
  logic               w_last_ch;
  logic               w_idle;
  logic               w_accept;
  logic [PHASE_W-1:0] w_step [8];
  logic [DATA_W-1:0]  w_sample [8];
  logic [23:0]        w_frame0;
  logic [23:0]        w_frame_next;

  function automatic logic [DATA_W-1:0] wave(input logic [DATA_W-1:0] p, input logic [1:0] mode);
    logic [DATA_W-1:0] dbl;
    dbl = p << 1;
    case (mode)
      2'd1:    wave = {DATA_W{p[DATA_W-1]}};
      2'd2:    wave = p;
      2'd3:    wave = p[DATA_W-1] ? ~dbl : dbl;
      default: wave = MID;
    endcase
  endfunction

  // Narrow samples are left-justified in the 16-bit data field.
  function automatic logic [23:0] make_frame(input logic [2:0] ch, input logic [DATA_W-1:0] s);
    logic [15:0] s16;
    s16 = 16'(s) << (16 - DATA_W);
    return {4'b0011, 1'b0, ch, s16};
  endfunction

  assign w_tick    = (r_tick_cnt == CNT_W'(SAMPLE_DIV - 1));
  assign w_last_ch = (r_ch == 3'(NUM_CH - 1));
  assign w_idle    = (r_state == S_IDLE) ||
                     ((r_state == S_GAP) && (r_div_cnt == '0) && w_last_ch);
  assign w_accept  = w_tick && enable_in && w_idle;

  always_comb begin
    for (int c = 0; c < 8; c++) begin
      w_step[c]   = '0;
      w_sample[c] = MID;
      if (c < NUM_CH) begin
        w_step[c]   = PHASE_W'((64'(switches_switches_in) + 64'd1) * 64'(BASE_STEP) * 64'(c + 1));
        w_sample[c] = wave(r_acc[c][PHASE_W-1 -: DATA_W], mode_in);
      end
    end
  end

  assign w_frame0     = make_frame(3'd0, w_sample[0]);
  assign w_frame_next = make_frame(r_ch + 3'd1, r_buf[r_ch + 3'd1]);

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      r_state           <= S_IDLE;
      r_tick_cnt        <= '0;
      r_latch           <= 1'b0;
      r_ch              <= '0;
      r_bit_cnt         <= '0;
      r_div_cnt         <= '0;
      r_shreg           <= '0;
      for (int c = 0; c < 8; c++) begin
        r_acc[c] <= '0;
        r_buf[c] <= '0;
      end
      spi_data_data     <= 1'b0;
      spi_data_spi_clk  <= 1'b1;
      spi_data_spi_sync <= 1'b1;
      dac_out_data_dac  <= MID;
      frame_done        <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
      r_latch    <= w_accept;
      // Accumulators advance on every enabled tick, even when its samples are dropped.
      if (w_tick && enable_in) begin
        for (int c = 0; c < 8; c++) r_acc[c] <= r_acc[c] + w_step[c];
        if (!w_idle) overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (r_latch) begin
            for (int c = 0; c < 8; c++) r_buf[c] <= w_sample[c];
            dac_out_data_dac  <= w_sample[0];
            r_ch              <= '0;
            r_shreg           <= w_frame0;
            spi_data_data     <= w_frame0[23];
            spi_data_spi_sync <= 1'b0;
            r_state           <= S_LOAD;
          end
        end
        S_LOAD: begin
          spi_data_spi_clk <= 1'b0;
          r_div_cnt        <= DIV_W'(SPI_DIV - 1);
          r_bit_cnt        <= 5'd23;
          r_state          <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_div_cnt != '0) begin
            r_div_cnt <= r_div_cnt - DIV_W'(1);
          end else if (!spi_data_spi_clk) begin
            spi_data_spi_clk <= 1'b1;
            r_shreg          <= r_shreg << 1;
            spi_data_data    <= r_shreg[22];
            r_div_cnt        <= DIV_W'(SPI_DIV - 1);
          end else if (r_bit_cnt == 5'd0) begin
            spi_data_spi_sync <= 1'b1;
            r_div_cnt         <= DIV_W'(2 * SPI_DIV - 1);
            r_state           <= S_GAP;
          end else begin
            spi_data_spi_clk <= 1'b0;
            r_bit_cnt        <= r_bit_cnt - 5'd1;
            r_div_cnt        <= DIV_W'(SPI_DIV - 1);
          end
        end
        S_GAP: begin
          if (r_div_cnt != '0) begin
            r_div_cnt <= r_div_cnt - DIV_W'(1);
          end else if (w_last_ch) begin
            spi_data_data <= 1'b0;
            frame_done    <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_ch              <= r_ch + 3'd1;
            r_shreg           <= w_frame_next;
            spi_data_data     <= w_frame_next[23];
            spi_data_spi_sync <= 1'b0;
            r_state           <= S_LOAD;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dac_tones_generator_mc.sv
// Bench for dac_tones_generator_mc: two instances (128- and 64-cycle sample
// periods) share stimulus; a timing-level reference model feeds a frame scoreboard.
module tb_dac_tones_generator_mc;
  localparam int FL  = 51;           // cycles per frame with SPI_DIV=1
  localparam int SEQ = 2 + 2 * FL;   // tick to frame_done for two channels

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en;
  logic [4:0] k;
  logic [1:0] mode;
  logic       w_sync [2];
  logic       w_sclk [2];
  logic       w_sdata [2];
  logic       w_done [2];
  logic       w_ovr [2];
  logic [15:0] w_dac [2];

  dac_tones_generator_mc #(.NUM_CH(2), .DATA_W(16), .PHASE_W(24), .SAMPLE_DIV(128),
                           .SPI_DIV(1), .BASE_STEP(1000)) u_dut (
    .clock_clk(clk), .reset_reset(rst), .switches_switches_in(k), .mode_in(mode),
    .enable_in(en), .spi_data_data(w_sdata[0]), .spi_data_spi_clk(w_sclk[0]),
    .spi_data_spi_sync(w_sync[0]), .dac_out_data_dac(w_dac[0]),
    .frame_done(w_done[0]), .overrun(w_ovr[0]));

  dac_tones_generator_mc #(.NUM_CH(2), .DATA_W(16), .PHASE_W(24), .SAMPLE_DIV(64),
                           .SPI_DIV(1), .BASE_STEP(1000)) u_dut_fast (
    .clock_clk(clk), .reset_reset(rst), .switches_switches_in(k), .mode_in(mode),
    .enable_in(en), .spi_data_data(w_sdata[1]), .spi_data_spi_clk(w_sclk[1]),
    .spi_data_spi_sync(w_sync[1]), .dac_out_data_dac(w_dac[1]),
    .frame_done(w_done[1]), .overrun(w_ovr[1]));

  typedef struct { int inst; int ch; int frame; longint start; int dac; } frame_t;
  typedef struct { int inst; longint at; } done_t;

  frame_t exp_q[$];
  done_t  done_q[$];
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;

  // reference model state
  int     cnt_m [2];
  longint acc_m [2][2];
  bit     pend_m [2];
  bit     have_last [2];
  longint last_t [2];
  bit     ovr_m [2];

  // monitor state
  bit     ps [2];
  bit     pc [2];
  int     nb [2];
  int     sh [2];
  longint st [2];
  int     dac_st [2];
  int     last_rx [2][2];
  bit     watch = 0;
  int     low_cnt = 0;
  bit     track = 0;
  bit     saw_rise = 0;
  int     last_s0 = -1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_sample(input longint acc, input int md);
    int p;
    p = int'(acc >> 8);
    case (md)
      1:       return (p >= 32768) ? 65535 : 0;
      2:       return p;
      3:       return (p < 32768) ? 2 * p : 131071 - 2 * p;
      default: return 32768;
    endcase
  endfunction

  task automatic model_step(input int i);
    int sd;
    sd = (i == 0) ? 128 : 64;
    if (rst) begin
      cnt_m[i] = 0; pend_m[i] = 0; have_last[i] = 0; ovr_m[i] = 0;
      acc_m[i][0] = 0; acc_m[i][1] = 0;
      return;
    end
    if (pend_m[i]) begin
      int s0;
      pend_m[i] = 0;
      s0 = ref_sample(acc_m[i][0], int'(mode));
      for (int c = 0; c < 2; c++) begin
        frame_t f;
        int s;
        s = ref_sample(acc_m[i][c], int'(mode));
        f.inst = i; f.ch = c; f.frame = (3 << 20) | (c << 16) | s;
        f.start = cyc + 1 + c * FL; f.dac = s0;
        exp_q.push_back(f);
      end
      done_q.push_back('{i, cyc + 1 + 2 * FL});
    end
    if (cnt_m[i] == sd - 1) begin
      cnt_m[i] = 0;
      if (en) begin
        for (int c = 0; c < 2; c++)
          acc_m[i][c] = (acc_m[i][c] + (int'(k) + 1) * 1000 * (c + 1)) % 16777216;
        if (have_last[i] && (cyc - last_t[i]) < SEQ - 1) ovr_m[i] = 1;
        else begin
          pend_m[i] = 1; have_last[i] = 1; last_t[i] = cyc;
        end
      end
    end else cnt_m[i]++;
  endtask

  task automatic end_frame(input int i);
    int idx;
    idx = -1;
    foreach (exp_q[j]) if (idx < 0 && exp_q[j].inst == i) idx = j;
    if (idx < 0) begin
      chk("frame_expected", 0, 1);
      return;
    end
    chk("frame_data", sh[i], exp_q[idx].frame);
    chk("frame_bits", nb[i], 24);
    chk("frame_start_cycle", st[i], exp_q[idx].start);
    if (exp_q[idx].ch == 0) chk("dac_out", dac_st[i], exp_q[idx].dac);
    chk("overrun_at_frame", w_ovr[i], ovr_m[i]);
    last_rx[i][exp_q[idx].ch] = sh[i];
    if (i == 0 && exp_q[idx].ch == 0) begin
      if (track && last_s0 == 0 && (sh[i] & 'hFFFF) == 'hFFFF) saw_rise = 1;
      last_s0 = sh[i] & 'hFFFF;
    end
    exp_q.delete(idx);
  endtask

  task automatic mon_step(input int i);
    if (rst) begin
      ps[i] = 1; pc[i] = 1; nb[i] = 0;
      return;
    end
    if (ps[i] && !w_sync[i]) begin
      nb[i] = 0; sh[i] = 0; st[i] = cyc; dac_st[i] = int'(w_dac[i]);
    end
    if (!w_sync[i] && pc[i] && !w_sclk[i]) begin
      sh[i] = (sh[i] << 1) | int'(w_sdata[i]);
      nb[i]++;
    end
    if (!ps[i] && w_sync[i]) end_frame(i);
    if (w_done[i]) begin
      int idx;
      idx = -1;
      foreach (done_q[j]) if (idx < 0 && done_q[j].inst == i) idx = j;
      if (idx < 0) chk("frame_done_expected", 0, 1);
      else begin
        chk("frame_done_cycle", cyc, done_q[idx].at);
        done_q.delete(idx);
      end
    end
    if (i == 0 && watch && !w_sync[0]) low_cnt++;
    ps[i] = w_sync[i];
    pc[i] = w_sclk[i];
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      done_q.delete();
    end
    model_step(0);
    model_step(1);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    mon_step(0);
    mon_step(1);
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; k = 5'd0; mode = 2'd2;
    run(3);
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      run(1);
      chk("reset_sync", w_sync[0], 1);
      chk("reset_sclk", w_sclk[0], 1);
      chk("reset_dac", w_dac[0], 16'h8000);
      chk("reset_overrun", w_ovr[0], 0);
    end
    run(280);
    chk("first_frame_ch0", last_rx[0][0], 24'h300003);
    chk("first_frame_ch1", last_rx[0][1], 24'h310007);

    for (int seg = 0; seg < 12; seg++) begin
      k    = 5'($urandom_range(0, 31));
      mode = 2'($urandom_range(0, 3));
      en   = ($urandom_range(0, 4) != 0);
      run(int'($urandom_range(60, 300)));
    end

    k = 5'($urandom_range(0, 31)); mode = 2'd0; en = 1'b1;
    run(400);
    chk("off_mode_ch0", last_rx[0][0], 24'h308000);
    chk("off_mode_ch1", last_rx[0][1], 24'h318000);

    en = 1'b0;
    run(120);
    watch = 1; low_cnt = 0;
    run(3 * 128 + 10);
    watch = 0;
    chk("sync_idle_while_disabled", low_cnt, 0);

    // reset mid-frame, at bit 10 of a channel-0 frame
    k = 5'd0; mode = 2'd2; en = 1'b1;
    begin
      bit hit;
      hit = 0;
      for (int n = 0; n < 2000 && !hit; n++) begin
        run(1);
        if (!w_sync[0] && nb[0] == 10 && (cyc - st[0]) < FL) hit = 1;
      end
      chk("reach_bit10", hit, 1);
    end
    rst = 1'b1;
    run(1);
    chk("midreset_sync", w_sync[0], 1);
    chk("midreset_sclk", w_sclk[0], 1);
    chk("midreset_dac", w_dac[0], 16'h8000);
    rst = 1'b0;
    run(290);
    chk("after_reset_ch0", last_rx[0][0], 24'h300003);
    chk("after_reset_ch1", last_rx[0][1], 24'h310007);

    k = 5'd31; mode = 2'd1; track = 1;
    run(36000);
    track = 0;
    chk("square_rise_seen", saw_rise, 1);
    chk("fast_overrun_sticky", w_ovr[1], 1);
    chk("slow_no_overrun", w_ovr[0], 0);

    en = 1'b0;
    run(250);
    chk("frames_pending", exp_q.size(), 0);
    chk("done_pending", done_q.size(), 0);
    chk("fast_overrun_held", w_ovr[1], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dac_tones_generator_mc.md
DAC_TONES_GENERATOR_MC -- requirements
Module: dac_tones_generator_mc

Interface
REQ-001 Parameter NUM_CH, default 2, number of tone channels, legal 1..8.
REQ-002 Parameter DATA_W, default 16, sample width, legal 8..16.
REQ-003 Parameter PHASE_W, default 24, phase accumulator width.
REQ-004 Parameter SAMPLE_DIV, default 1000, clocks per sample tick, minimum 2.
REQ-005 Parameter SPI_DIV, default 2, clocks per spi_clk half-period, minimum 1.
REQ-006 Parameter BASE_STEP, default 1000, base tuning word.
REQ-007 clock_clk  in  1  single clock; all logic on its rising edge.
REQ-008 reset_reset  in  1  synchronous, active-high reset.
REQ-009 switches_switches_in  in  5  tone index k (0..31).
REQ-010 mode_in  in  2  waveform: 0 off, 1 square, 2 sawtooth, 3 triangle.
REQ-011 enable_in  in  1  high: accumulators advance and frames are sent.
REQ-012 spi_data_data  out  1  serial data, MSB first.
REQ-013 spi_data_spi_clk  out  1  serial clock, idle high.
REQ-014 spi_data_spi_sync  out  1  frame strobe, active low.
REQ-015 dac_out_data_dac  out  DATA_W  last sample sent on channel 0.
REQ-016 frame_done  out  1  one-cycle pulse after the last channel's frame completes.
REQ-017 overrun  out  1  sticky flag: a tick arrived while frames were still in flight.

Function
REQ-018 Tick counter: counts 0..SAMPLE_DIV-1 and wraps; tick is the cycle with count == SAMPLE_DIV-1; the counter runs regardless of enable_in.
REQ-019 Channel c tuning word: step_c = (k+1)*BASE_STEP*(c+1), truncated to PHASE_W; k is sampled on the tick cycle.
REQ-020 On a tick with enable_in=1, each accumulator takes acc_c + step_c modulo 2^PHASE_W; on a tick with enable_in=0, accumulators hold and no frames are started.
REQ-021 Waveform source: p = acc_c[PHASE_W-1 -: DATA_W]. Saw = p. Square = all ones if p MSB is 1, else all zeros. Triangle = (p<<1) if MSB is 0, else ~(p<<1). Off = 2^(DATA_W-1).
REQ-022 Samples for all channels are latched into a sample buffer on the cycle after the tick; mode_in is sampled on that cycle.
REQ-023 FSM states: IDLE, LOAD, SHIFT, GAP. IDLE goes to LOAD when the buffer is latched. LOAD goes to SHIFT after 1 cycle. SHIFT goes to GAP after 24 bits. GAP goes to LOAD (next channel) or to IDLE (last channel) after 2*SPI_DIV cycles.
REQ-024 Frame (24 bits) = {4'b0011, channel[3:0], sample, (16-DATA_W) zero bits}; channels are sent in ascending order 0..NUM_CH-1.
REQ-025 LOAD: spi_sync goes low, spi_clk stays high, and spi_data carries the frame MSB.
REQ-026 SHIFT, per bit: spi_clk is low for SPI_DIV cycles and then high for SPI_DIV cycles; spi_data changes only on the rising edge of spi_clk; the DAC samples on the falling edge.
REQ-027 At the end of SHIFT, spi_clk is high; spi_sync goes high on the first cycle of GAP and remains high through GAP.
REQ-028 Frame latency: channel 0's LOAD begins 2 cycles after the tick; one frame lasts 1+48*SPI_DIV+2*SPI_DIV cycles.
REQ-029 dac_out_data_dac updates to channel 0's sample on the cycle its LOAD begins.
REQ-030 frame_done pulses on the cycle the last GAP transitions to IDLE.
REQ-031 Tick while not in IDLE (simultaneous tick and GAP-to-IDLE counts as in IDLE): accumulators still advance, that tick's samples are dropped, overrun is set, and the current frames complete unchanged.
REQ-032 enable_in deasserted mid-frame: the frame sequence in progress completes; no new sequence starts.
REQ-033 overrun clears only on reset.

Reset
REQ-034 Reset outputs: spi_sync=1, spi_clk=1, spi_data=0, dac_out_data_dac=2^(DATA_W-1), frame_done=0, overrun=0.
REQ-035 Reset clears accumulators, the tick counter and the buffer, and puts the FSM in IDLE.
REQ-036 Reset asserted mid-frame forces the reset outputs on the next clock edge; no partial frame resumes after reset.

Verification (NUM_CH=2, DATA_W=16, PHASE_W=24, SAMPLE_DIV=128, SPI_DIV=1, BASE_STEP=1000)
REQ-037 Reset, then hold outputs 10 cycles -> spi_sync=1, spi_clk=1, dac=0x8000, overrun=0.
REQ-038 k=0, mode=2, enable=1, first tick -> acc0=1000, acc1=2000; frame 0 = 0x30_0003, frame 1 = 0x31_0007; 24 falling edges per frame; frame_done pulses 2+2*51 cycles after the tick.
REQ-039 k=31, mode=1, run until acc0 crosses 0x800000 -> channel-0 sample switches 0x0000 to 0xFFFF; acc wraps modulo 2^24 with no glitch.
REQ-040 SAMPLE_DIV=64 with NUM_CH=2 -> second tick lands inside frame 1; overrun=1 and stays 1; the next ticks' frames are dropped or sent per REQ-031.
REQ-041 Assert reset for 1 cycle at bit 10 of frame 0 -> next cycle spi_sync=1 and spi_clk=1; the next tick starts from acc=1000.
REQ-042 mode=0 -> every frame carries data 0x8000; enable=0 -> spi_sync stays high across 3 ticks.
